// File: rtl/carfield_periph_apb_router.sv
// APB demux from the SoC peripheral port to the Carfield peripherals with registered re-issue and response.
// Optional hung-slave abort is compiled in with CARFIELD_APB_ROUTER_TIMEOUT_EN.
module carfield_periph_apb_router #(
    parameter int unsigned                NumSlv        = 6,
    parameter logic [NumSlv-1:0][31:0]    SlvBase       = {32'h2002_9000, 32'h2000_9000, 32'h2000_7000,
                                                           32'h2000_5000, 32'h2000_4000, 32'h2000_1000},
    parameter logic [NumSlv-1:0][31:0]    SlvSize       = {32'h0000_8000, 32'h0000_1000, 32'h0000_1000,
                                                           32'h0000_1000, 32'h0000_1000, 32'h0000_1000},
    parameter logic [NumSlv-1:0]          SlvEnable     = 6'b111111,
    parameter int unsigned                TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            s_paddr_i,
    input  logic                   s_psel_i,
    input  logic                   s_penable_i,
    input  logic                   s_pwrite_i,
    input  logic [31:0]            s_pwdata_i,
    input  logic [3:0]             s_pstrb_i,
    output logic [31:0]            s_prdata_o,
    output logic                   s_pready_o,
    output logic                   s_pslverr_o,
    output logic [31:0]            m_paddr_o,
    output logic                   m_pwrite_o,
    output logic                   m_penable_o,
    output logic [31:0]            m_pwdata_o,
    output logic [3:0]             m_pstrb_o,
    output logic [NumSlv-1:0]      m_psel_o,
    input  logic [NumSlv*32-1:0]   m_prdata_i,
    input  logic [NumSlv-1:0]      m_pready_i,
    input  logic [NumSlv-1:0]      m_pslverr_i,
    output logic                   timeout_o
);

    localparam int unsigned IdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DSETUP  = 3'd1;
    localparam logic [2:0] DACCESS = 3'd2;
    localparam logic [2:0] RESP    = 3'd3;
    localparam logic [2:0] ERR     = 3'd4;

    localparam logic [NumSlv-1:0] SelOne  = {{(NumSlv-1){1'b0}}, 1'b1};
    localparam logic [31:0]       AbortData = 32'hBADC_AB1E;

    logic [2:0]        state_q, state_d;
    logic [31:0]       addr_q, wdata_q;
    logic              write_q;
    logic [3:0]        strb_q;
    logic [IdxW-1:0]   idx_q, idx_d, dec_idx_s;
    logic              dec_hit_s, latch_s, slv_ready_s, abort_s;
    logic [31:0]       rsp_data_s;
    logic              rsp_err_s;

    logic [31:0]       prdata_q;
    logic              pready_q, pslverr_q, penable_q, timeout_q;
    logic [NumSlv-1:0] psel_q;

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

    // Address decode; scanning downwards lets the lowest matching index win
    always_comb begin
        dec_hit_s = 1'b0;
        dec_idx_s = '0;
        for (int i = NumSlv - 1; i >= 0; i--) begin
            dec_idx_s = (SlvEnable[i] && in_window(s_paddr_i, SlvBase[i], SlvSize[i])) ? IdxW'(i) : dec_idx_s;
            dec_hit_s = dec_hit_s | (SlvEnable[i] && in_window(s_paddr_i, SlvBase[i], SlvSize[i]));
        end
    end

    assign latch_s     = (state_q == IDLE) && s_psel_i && !s_penable_i;
    assign idx_d       = latch_s ? dec_idx_s : idx_q;
    assign slv_ready_s = m_pready_i[idx_q];

`ifdef CARFIELD_APB_ROUTER_TIMEOUT_EN
    localparam logic [15:0] ToLast = 16'(TimeoutCycles - 1);
    logic [15:0] cnt_q, cnt_d;

    // Count unanswered ACCESS cycles; anything else (including ACCESS entry) clears it
    always_comb begin
        if ((state_q == DACCESS) && !slv_ready_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    assign abort_s = (state_q == DACCESS) && !slv_ready_s && (cnt_q == ToLast);

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] timeout_cfg_unused_s;
    assign timeout_cfg_unused_s = 32'(TimeoutCycles);
    assign abort_s              = 1'b0;
`endif

    // Transfer sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (latch_s) begin
                    state_d = dec_hit_s ? DSETUP : ERR;
                end else begin
                    state_d = IDLE;
                end
            end
            DSETUP:  state_d = DACCESS;
            DACCESS: begin
                if (slv_ready_s || abort_s) begin
                    state_d = RESP;
                end else begin
                    state_d = DACCESS;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response payload captured on leaving ACCESS
    always_comb begin
        if (abort_s) begin
            rsp_data_s = AbortData;
            rsp_err_s  = 1'b1;
        end else begin
            rsp_data_s = m_prdata_i[32*idx_q +: 32];
            rsp_err_s  = m_pslverr_i[idx_q];
        end
    end

    // Latched request and FSM state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            strb_q  <= 4'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch_s) begin
                addr_q  <= s_paddr_i;
                wdata_q <= s_pwdata_i;
                write_q <= s_pwrite_i;
                strb_q  <= s_pstrb_i;
            end
        end
    end

    // Outputs are registered from next state, so no m_* input reaches an s_* output combinationally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prdata_q  <= 32'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pready_q  <= (state_d == RESP) || (state_d == ERR);
            pslverr_q <= (state_d == RESP) ? rsp_err_s : (state_d == ERR);
            prdata_q  <= (state_d == RESP) ? rsp_data_s : 32'd0;
            psel_q    <= ((state_d == DSETUP) || (state_d == DACCESS)) ? (SelOne << idx_d) : '0;
            penable_q <= (state_d == DACCESS);
            timeout_q <= abort_s;
        end
    end

    assign s_prdata_o  = prdata_q;
    assign s_pready_o  = pready_q;
    assign s_pslverr_o = pslverr_q;
    assign m_paddr_o   = addr_q;
    assign m_pwrite_o  = write_q;
    assign m_pwdata_o  = wdata_q;
    assign m_pstrb_o   = strb_q;
    assign m_psel_o    = psel_q;
    assign m_penable_o = penable_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_carfield_periph_apb_router.sv
// Self-checking bench for carfield_periph_apb_router: scoreboarded upstream transfers against modelled slaves.
module tb_carfield_periph_apb_router;
    localparam int NS = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       s_paddr_i, s_pwdata_i;
    logic              s_psel_i, s_penable_i, s_pwrite_i;
    logic [3:0]        s_pstrb_i;
    logic [31:0]       s_prdata_o, m_paddr_o, m_pwdata_o;
    logic              s_pready_o, s_pslverr_o, m_pwrite_o, m_penable_o, timeout_o;
    logic [3:0]        m_pstrb_o;
    logic [NS-1:0]     m_psel_o, m_pready_i, m_pslverr_i;
    logic [NS*32-1:0]  m_prdata_i;

    logic [NS-1:0]     hang;
    logic [NS-1:0]     serr;
    int                ws [NS];
    logic [31:0]       sd [NS];
    int                acc_cnt [NS];

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int to_pulses = 0;

    always #5 clk = ~clk;

    carfield_periph_apb_router #(
        .SlvEnable     (6'b111110),
        .TimeoutCycles (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_paddr_i   (s_paddr_i),
        .s_psel_i    (s_psel_i),
        .s_penable_i (s_penable_i),
        .s_pwrite_i  (s_pwrite_i),
        .s_pwdata_i  (s_pwdata_i),
        .s_pstrb_i   (s_pstrb_i),
        .s_prdata_o  (s_prdata_o),
        .s_pready_o  (s_pready_o),
        .s_pslverr_o (s_pslverr_o),
        .m_paddr_o   (m_paddr_o),
        .m_pwrite_o  (m_pwrite_o),
        .m_penable_o (m_penable_o),
        .m_pwdata_o  (m_pwdata_o),
        .m_pstrb_o   (m_pstrb_o),
        .m_psel_o    (m_psel_o),
        .m_prdata_i  (m_prdata_i),
        .m_pready_i  (m_pready_i),
        .m_pslverr_i (m_pslverr_i),
        .timeout_o   (timeout_o)
    );

    // Slave models: ready after ws[i] extra ACCESS cycles unless hung
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            acc_cnt[i] <= (m_psel_o[i] && m_penable_o) ? acc_cnt[i] + 1 : 0;
        end
    end

    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign m_pready_i[g]         = m_psel_o[g] && m_penable_o && !hang[g] && (acc_cnt[g] >= ws[g]);
        assign m_pslverr_i[g]        = serr[g];
        assign m_prdata_i[32*g +: 32] = sd[g];
    end

    // Abort pulse counter
    always @(negedge clk) begin
        if (timeout_o) to_pulses <= to_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_response", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "/rdata"}, s_prdata_o, e.data);
            check_eq({e.tag, "/pslverr"}, {31'd0, s_pslverr_o}, {31'd0, e.err});
        end
    endtask

    // One upstream transfer; observes downstream phases and upstream wait states
    task automatic apb_xfer(input string tag, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st, input logic [NS-1:0] esel,
                            input logic [31:0] edata, input logic eerr, input int ewait);
        exp_t e;
        int   n;
        e.tag = tag; e.data = edata; e.err = eerr;
        exp_q.push_back(e);
        s_paddr_i = addr; s_pwrite_i = wr; s_pwdata_i = wd; s_pstrb_i = st;
        s_psel_i = 1'b1; s_penable_i = 1'b0;
        @(negedge clk);
        s_penable_i = 1'b1;
        n = 1;
        check_eq({tag, "/sel_t1"}, {26'd0, m_psel_o}, {26'd0, esel});
        check_eq({tag, "/penable_t1"}, {31'd0, m_penable_o}, 32'd0);
        check_eq({tag, "/paddr_t1"}, m_paddr_o, addr);
        check_eq({tag, "/pwrite_t1"}, {31'd0, m_pwrite_o}, {31'd0, wr});
        while (!s_pready_o && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 2 && esel != '0) begin
                check_eq({tag, "/sel_t2"}, {26'd0, m_psel_o}, {26'd0, esel});
                check_eq({tag, "/penable_t2"}, {31'd0, m_penable_o}, 32'd1);
                check_eq({tag, "/pwdata_t2"}, m_pwdata_o, wd);
                check_eq({tag, "/pstrb_t2"}, {28'd0, m_pstrb_o}, {28'd0, st});
                check_eq({tag, "/quiet_t2"}, s_prdata_o | {31'd0, s_pslverr_o}, 32'd0);
            end
        end
        check_eq({tag, "/wait_states"}, n - 1, ewait);
        if (s_pready_o) sb_compare();
        else exp_q.delete();
        @(negedge clk);
        s_psel_i = 1'b0; s_penable_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        logic seen;
        rst_n = 1'b0;
        s_paddr_i = 32'd0; s_pwdata_i = 32'd0; s_pstrb_i = 4'd0;
        s_psel_i = 1'b0; s_penable_i = 1'b0; s_pwrite_i = 1'b0;
        hang = '0; serr = '0;
        for (int i = 0; i < NS; i++) begin
            ws[i] = 0;
            sd[i] = 32'hD000_0000 | 32'(i);
        end
        repeat (2) @(negedge clk);
        check_eq("rst/prdata", s_prdata_o, 32'd0);
        check_eq("rst/pready_pslverr", {30'd0, s_pready_o, s_pslverr_o}, 32'd0);
        check_eq("rst/psel_penable", {25'd0, m_psel_o, m_penable_o}, 32'd0);
        check_eq("rst/paddr", m_paddr_o, 32'd0);
        check_eq("rst/pwdata", m_pwdata_o, 32'd0);
        check_eq("rst/pstrb_pwrite_to", {27'd0, m_pstrb_o, m_pwrite_o}, {31'd0, timeout_o});
        rst_n = 1'b1;
        @(negedge clk);

        sd[1] = 32'h1234_5678;
        apb_xfer("rd_systimer", 32'h2000_4010, 1'b0, 32'h0, 4'h0, 6'b000010, 32'h1234_5678, 1'b0, 2);
        apb_xfer("wr_streamer", 32'h2002_F000, 1'b1, 32'hA5A5_A5A5, 4'hF, 6'b100000, sd[5], 1'b0, 2);
        apb_xfer("streamer_last", 32'h2003_0FFC, 1'b0, 32'h0, 4'h3, 6'b100000, sd[5], 1'b0, 2);
        apb_xfer("miss_past_streamer", 32'h2003_1000, 1'b0, 32'h0, 4'h0, 6'b000000, 32'd0, 1'b1, 0);
        apb_xfer("miss_gap", 32'h2000_2000, 1'b0, 32'h0, 4'h0, 6'b000000, 32'd0, 1'b1, 0);
        apb_xfer("miss_can_disabled", 32'h2000_1000, 1'b0, 32'h0, 4'h0, 6'b000000, 32'd0, 1'b1, 0);
        apb_xfer("miss_top", 32'hFFFF_FFF0, 1'b0, 32'h0, 4'h0, 6'b000000, 32'd0, 1'b1, 0);
        apb_xfer("systimer_last", 32'h2000_4FFC, 1'b0, 32'h0, 4'h0, 6'b000010, 32'h1234_5678, 1'b0, 2);

        ws[2] = 3; serr[2] = 1'b1; sd[2] = 32'hCAFE_F00D;
        apb_xfer("advtimer_ws3_err", 32'h2000_5000, 1'b0, 32'h0, 4'h0, 6'b000100, 32'hCAFE_F00D, 1'b1, 5);
        ws[2] = 0; serr[2] = 1'b0;

        hang[3] = 1'b1;
`ifdef CARFIELD_APB_ROUTER_TIMEOUT_EN
        apb_xfer("wdog_timeout", 32'h2000_7000, 1'b0, 32'h0, 4'h0, 6'b001000, 32'hBADC_AB1E, 1'b1, 9);
        check_eq("wdog_timeout/pulses", to_pulses, 32'd1);
        hang[3] = 1'b0;
`else
        e.tag = "wdog_stall"; e.data = sd[3]; e.err = 1'b0;
        exp_q.push_back(e);
        s_paddr_i = 32'h2000_7000; s_pwrite_i = 1'b0; s_psel_i = 1'b1; s_penable_i = 1'b0;
        @(negedge clk);
        s_penable_i = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | s_pready_o;
        end
        check_eq("wdog_stall/no_pready", {31'd0, seen}, 32'd0);
        check_eq("wdog_stall/psel", {26'd0, m_psel_o}, 32'h08);
        check_eq("wdog_stall/penable", {31'd0, m_penable_o}, 32'd1);
        check_eq("wdog_stall/pulses", to_pulses, 32'd0);
        hang[3] = 1'b0;
        n = 0;
        while (!s_pready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("wdog_stall/released", {31'd0, s_pready_o}, 32'd1);
        if (s_pready_o) sb_compare();
        else exp_q.delete();
        @(negedge clk);
        s_psel_i = 1'b0; s_penable_i = 1'b0;
`endif

        ws[4] = 5;
        s_paddr_i = 32'h2000_9000; s_pwrite_i = 1'b1; s_pwdata_i = 32'h5555_AAAA; s_pstrb_i = 4'hC;
        s_psel_i = 1'b1; s_penable_i = 1'b0;
        @(negedge clk);
        s_penable_i = 1'b1;
        @(negedge clk);
        check_eq("rstmid/psel_access", {26'd0, m_psel_o}, 32'h10);
        check_eq("rstmid/penable_access", {31'd0, m_penable_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstmid/psel", {26'd0, m_psel_o}, 32'd0);
        check_eq("rstmid/penable_pready", {30'd0, m_penable_o, s_pready_o}, 32'd0);
        check_eq("rstmid/paddr", m_paddr_o, 32'd0);
        check_eq("rstmid/pwdata", m_pwdata_o, 32'd0);
        check_eq("rstmid/pstrb_pwrite", {27'd0, m_pstrb_o, m_pwrite_o}, 32'd0);
        s_psel_i = 1'b0; s_penable_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ws[4] = 0;
        @(negedge clk);
        apb_xfer("hyper_after_rst", 32'h2000_9000, 1'b0, 32'h0, 4'h0, 6'b010000, sd[4], 1'b0, 2);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/carfield_periph_apb_router.md
# carfield_periph_apb_router

APB demultiplexer and response stage that sits directly downstream of the SoC peripheral APB port and upstream of the Carfield APB peripherals: CAN, system timer, advanced timer, watchdog, HyperBus config and streamer APB. It decodes each upstream transfer against a fixed base/size map with per-slave enables. It re-issues the transfer as a fresh registered APB transfer on the selected slave and returns a registered response. Unmapped or disabled targets are answered locally with PSLVERR. An optional watchdog counter aborts hung slaves.

## Interface
- NumSlv, 6: number of downstream slaves. Index order: 0 CAN, 1 SysTimer, 2 AdvTimer, 3 Watchdog, 4 HyperBus, 5 Streamer.
- SlvBase, {0x20001000, 0x20004000, 0x20005000, 0x20007000, 0x20009000, 0x20029000}: 32-bit base of each slave.
- SlvSize, {0x1000, 0x1000, 0x1000, 0x1000, 0x1000, 0x8000}: byte size of each slave.
- SlvEnable, 6'b111111: per-slave enable. Bit 0 follows CanEnable; bit 5 follows StreamerEnable.
- TimeoutCycles, 256: downstream ACCESS cycles before abort. Range 2..65535.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- s_paddr_i  in  32  upstream address
- s_psel_i, s_penable_i, s_pwrite_i  in  1 each  upstream control
- s_pwdata_i  in  32  upstream write data
- s_pstrb_i  in  4  upstream byte strobes
- s_prdata_o  out  32  response data
- s_pready_o  out  1  response ready
- s_pslverr_o  out  1  response error
- m_paddr_o  out  32  shared downstream address
- m_pwrite_o, m_penable_o  out  1 each  shared downstream control
- m_pwdata_o  out  32  shared write data
- m_pstrb_o  out  4  shared strobes
- m_psel_o  out  NumSlv  one-hot slave select
- m_prdata_i  in  NumSlv*32  slave read data; slave i occupies [32i+31:32i]
- m_pready_i, m_pslverr_i  in  NumSlv each  slave ready and error
- timeout_o  out  1  one-cycle pulse on abort

## Operation
- FSM states: IDLE, DSETUP, DACCESS, RESP, ERR.
- IDLE: when s_psel_i=1 and s_penable_i=0, latch paddr, pwrite, pwdata and pstrb, then decode.
- Decode: hit(i) = SlvEnable[i] and SlvBase[i] <= addr < SlvBase[i]+SlvSize[i]. Use 33-bit arithmetic so the range cannot wrap.
- Multiple hits: the lowest index wins.
- Decode result: a hit goes to DSETUP; no hit goes to ERR.
- DSETUP: drive m_psel_o[idx]=1 and m_penable_o=0. Go to DACCESS.
- DACCESS: drive m_psel_o[idx]=1 and m_penable_o=1.
  - When m_pready_i[idx]=1, register prdata and pslverr of slave idx, then go to RESP.
  - With timeout compiled in, when the counter reaches TimeoutCycles-1 with no ready, drop psel/penable, register rdata=0xBADCAB1E and slverr=1, pulse timeout_o, then go to RESP.
- RESP: for exactly one cycle, s_pready_o=1, s_prdata_o=registered data, s_pslverr_o=registered error. Go to IDLE.
- ERR: for one cycle, s_pready_o=1, s_pslverr_o=1, s_prdata_o=0. Go to IDLE.
- Outside RESP and ERR, s_pready_o=0, s_pslverr_o=0 and s_prdata_o=0.
- m_paddr_o, m_pwrite_o, m_pwdata_o and m_pstrb_o hold the latched values in every state and change only on a new IDLE latch.
- Write transfers: the registered prdata is still captured but carries no meaning.
- Upstream drops s_psel_i mid-transfer (protocol violation): the downstream transfer completes, the response is still emitted for one cycle, and no retry occurs.
- Reset asserted mid-transfer: every output goes to 0 asynchronously, the FSM returns to IDLE and the counter clears.

## Timing
- Reset values: all outputs 0, m_psel_o all zeros, timeout_o=0.
- Hit with a zero-wait slave:
  - Upstream setup at cycle T0.
  - Downstream DSETUP at T1.
  - Downstream DACCESS at T2, with m_pready_i=1.
  - Upstream s_pready_o=1 at T3, giving 2 wait states upstream.
- A slave with k wait states adds k upstream wait states.
- Miss: s_pready_o=1 with s_pslverr_o=1 at T1.
- Back-to-back: a new upstream setup is accepted in the IDLE cycle right after RESP or ERR.
- No combinational path from any m_* input to any s_* output.
- The timeout counter is 16 bits. It clears on DACCESS entry and increments each DACCESS cycle with no ready.
- Abort occurs in DACCESS cycle number TimeoutCycles.

## Configuration
- CARFIELD_APB_ROUTER_TIMEOUT_EN defined: the timeout counter and abort path exist, and timeout_o pulses as specified.
- Undefined: no counter, DACCESS waits indefinitely for m_pready_i, and timeout_o is tied to 0.

## Test plan
- Read 0x20004010, with slave 1 returning 0x12345678 and zero wait states -> m_psel_o=6'b000010 at T1, penable at T2, upstream prdata=0x12345678 with pready at T3 and pslverr=0.
- Write 0x2002F000 data 0xA5A5A5A5 strobe 0xF -> m_psel_o=6'b100000, with m_pwdata_o and m_pstrb_o unchanged through DACCESS. Address 0x20031000 -> ERR.
- Read 0x20002000 (unmapped), and read 0x20001000 with SlvEnable[0]=0 -> no m_psel_o asserted, pready and pslverr=1 at T1, prdata=0.
- Slave 3 holds pready=0, with the macro defined and TimeoutCycles=8 -> abort after 8 DACCESS cycles, timeout_o pulses once, upstream pslverr=1 with prdata=0xBADCAB1E. Without the macro, the FSM stalls in DACCESS.
- rst_ni pulled low during DACCESS with slave 4 selected -> all outputs 0 immediately. After release, the next transfer to 0x20009000 completes normally.
- Slave 2 with 3 wait states asserting pslverr=1 -> upstream pready at T6 with pslverr=1 and slave data passed through.
